// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the packed-BCD incrementor.
// Digits are 4-bit nibbles holding 0-9; codes A-F are treated as invalid.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    function automatic logic is_valid_digit(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_inc.sv
// Combinational single-digit BCD incrementer, one link of the ripple chain.
// Any digit at or above 9 (including codes A-F) rolls to 0 when a carry arrives.
module bcd_digit_inc
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       carry_in,
    output bcd_digit_t digit_out,
    output logic       carry_out,
    output logic       invalid
);

    logic at_top;

    assign at_top  = (digit >= BCD_MAX);
    assign invalid = !is_valid_digit(digit);

    always_comb begin
        digit_out = digit;
        carry_out = 1'b0;
        if (carry_in) begin
            if (at_top) begin
                digit_out = '0;
                carry_out = 1'b1;
            end else begin
                digit_out = digit + bcd_digit_t'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_incrementor.sv
// Registered packed-BCD +1 stage with decimal carry and wrap flag, 1-cycle latency.
// Optional macro BCD_CHECK_EN: invalid digits pass the operand through and raise err.
module bcd_incrementor
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] in_bcd,
    output logic                              out_valid,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] out_bcd,
    output logic                              carry_out,
    output logic                              err
);

    localparam int W = BCD_DIGIT_W * NUM_DIGITS;

    logic [NUM_DIGITS:0]   carry_chain;
    logic [W-1:0]          inc_bcd;
    logic [NUM_DIGITS-1:0] digit_invalid;
    logic                  any_invalid;

    logic                  out_valid_reg;
    logic [W-1:0]          out_bcd_reg;
    logic                  carry_reg;
    logic                  err_reg;

    logic [W-1:0]          out_bcd_next;
    logic                  carry_next;
    logic                  err_next;

    // Digit 0 always receives the +1.
    assign carry_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_inc u_digit (
                .digit     (in_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .carry_in  (carry_chain[gi]),
                .digit_out (inc_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .carry_out (carry_chain[gi+1]),
                .invalid   (digit_invalid[gi])
            );
        end
    endgenerate

    assign any_invalid = |digit_invalid;

`ifdef BCD_CHECK_EN
    always_comb begin
        out_bcd_next = inc_bcd;
        carry_next   = carry_chain[NUM_DIGITS];
        err_next     = 1'b0;
        if (any_invalid) begin
            out_bcd_next = in_bcd;
            carry_next   = 1'b0;
            err_next     = 1'b1;
        end
    end
`else
    // Without checking, invalid digits simply follow the >=9 roll-over rule.
    logic invalid_unused;
    assign invalid_unused = any_invalid;

    always_comb begin
        out_bcd_next = inc_bcd;
        carry_next   = carry_chain[NUM_DIGITS];
        err_next     = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_bcd_reg   <= '0;
            carry_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_bcd_reg <= out_bcd_next;
                carry_reg   <= carry_next;
                err_reg     <= err_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bcd   = out_bcd_reg;
    assign carry_out = carry_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_bcd_incrementor.sv
// Self-checking bench for bcd_incrementor: directed cases plus random BCD traffic
// compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_incrementor;

    localparam int ND = 3;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b1;
    logic [W-1:0] in_bcd = 12'h123;
    logic         out_valid;
    logic [W-1:0] out_bcd;
    logic         carry_out;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;

    logic         m_valid = 1'b0;
    logic [W-1:0] m_bcd   = '0;
    logic         m_carry = 1'b0;
    logic         m_err   = 1'b0;
    logic [W-1:0] mr;
    logic         mc, me;

    bcd_incrementor #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .carry_out (carry_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal arithmetic for well-formed operands; for malformed ones,
    // all trailing digits >= 9 become 0 and the lowest digit below 9 gains one.
    function automatic void model_inc(input logic [W-1:0] d, output logic [W-1:0] r,
                                      output logic c, output logic e);
        logic bad;
        int   v;
        int   first;
        bad = 1'b0;
        for (int k = 0; k < ND; k++) if (d[4*k +: 4] > 4'd9) bad = 1'b1;
        r = d; c = 1'b0; e = 1'b0;
`ifdef BCD_CHECK_EN
        if (bad) begin
            e = 1'b1;
            return;
        end
`endif
        if (!bad) begin
            v = 0;
            for (int k = ND - 1; k >= 0; k--) v = v * 10 + int'(d[4*k +: 4]);
            v = v + 1;
            c = (v == 1000);
            v = v % 1000;
            for (int k = 0; k < ND; k++) begin
                r[4*k +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end else begin
            first = -1;
            for (int k = ND - 1; k >= 0; k--) if (d[4*k +: 4] < 4'd9) first = k;
            if (first < 0) begin
                r = '0;
                c = 1'b1;
            end else begin
                for (int k = 0; k < first; k++) r[4*k +: 4] = 4'd0;
                r[4*first +: 4] = d[4*first +: 4] + 4'd1;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_carry <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                model_inc(in_bcd, mr, mc, me);
                m_bcd   <= mr;
                m_carry <= mc;
                m_err   <= me;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_valid", 32'(out_valid), 32'(m_valid));
            check("cmp_bcd",   32'(out_bcd),   32'(m_bcd));
            check("cmp_carry", 32'(carry_out), 32'(m_carry));
            check("cmp_err",   32'(err),       32'(m_err));
        end
    end

    task automatic step(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        in_valid = v;
        in_bcd   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [W-1:0] b,
                              input logic c, input logic e);
        check({name, "_valid"}, 32'(out_valid), 32'(v));
        check({name, "_bcd"},   32'(out_bcd),   32'(b));
        check({name, "_carry"}, 32'(carry_out), 32'(c));
        check({name, "_err"},   32'(err),       32'(e));
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] d;
        int sel;
        for (int k = 0; k < ND; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel < 3)       d[4*k +: 4] = 4'd9;
            else if (sel == 7) d[4*k +: 4] = 4'($urandom_range(10, 15));
            else               d[4*k +: 4] = 4'($urandom_range(0, 8));
        end
        return d;
    endfunction

    initial begin
        logic [W-1:0] rv;
        #1 rst_n = 1'b0;
        #2 expect_out("rst_async", 1'b0, 12'h000, 1'b0, 1'b0);
        #4 expect_out("rst_hold", 1'b0, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 12'h123); expect_out("nocarry", 1'b1, 12'h124, 1'b0, 1'b0);
        step(1'b0, 12'h777); expect_out("idle_hold", 1'b0, 12'h124, 1'b0, 1'b0);

        step(1'b1, 12'h129); expect_out("chain0", 1'b1, 12'h130, 1'b0, 1'b0);
        step(1'b1, 12'h199); expect_out("chain1", 1'b1, 12'h200, 1'b0, 1'b0);
        step(1'b1, 12'h409); expect_out("chain2", 1'b1, 12'h410, 1'b0, 1'b0);

        step(1'b1, 12'h999); expect_out("wrap", 1'b1, 12'h000, 1'b1, 1'b0);
        step(1'b1, 12'h000); expect_out("after_wrap", 1'b1, 12'h001, 1'b0, 1'b0);

        step(1'b1, 12'h555); expect_out("pre_rst", 1'b1, 12'h556, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        in_bcd   = 12'h321;
        rst_n    = 1'b0;
        #1 expect_out("rst_mid", 1'b0, 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 12'h058); expect_out("post_rst", 1'b1, 12'h059, 1'b0, 1'b0);

`ifdef BCD_CHECK_EN
        step(1'b1, 12'h1A9); expect_out("invalid", 1'b1, 12'h1A9, 1'b0, 1'b1);
        step(1'b1, 12'h998); expect_out("err_clear", 1'b1, 12'h999, 1'b0, 1'b0);
`else
        step(1'b1, 12'h1A9); expect_out("invalid", 1'b1, 12'h200, 1'b0, 1'b0);
        step(1'b1, 12'hFF9); expect_out("invalid_wrap", 1'b1, 12'h000, 1'b1, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            rv = rand_bcd();
            step(($urandom_range(0, 3) != 0), rv);
        end
        step(1'b0, 12'h000);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_incrementor.md
Name: bcd_incrementor

Overview:
Registered packed-BCD +1 incrementor. Takes an NUM_DIGITS-digit packed BCD word (default 3 digits, 12 bits) and returns the value plus one in packed BCD, with decimal carry between digits and a wrap-around flag. One-cycle pipeline stage, used wherever decimal counters or displays need a "next value" computation.

Parameters:
NUM_DIGITS, 3, number of 4-bit BCD digits; digit 0 is the least significant, at bits [3:0].

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_bcd is valid this cycle
in_bcd  input  4*NUM_DIGITS  packed BCD operand; digit k is at [4k+3:4k]
out_valid  output  1  out_bcd, carry_out and err are valid
out_bcd  output  4*NUM_DIGITS  registered in_bcd + 1, in packed BCD
carry_out  output  1  set when all digits are 9 and the result wrapped to 0
err  output  1  invalid-digit flag; driven only when BCD_CHECK_EN is defined, otherwise tied 0

Behaviour:
- Reset: rst_n low asynchronously clears out_valid, out_bcd, carry_out and err to 0.
  - Release is synchronous to clk.
  - A reset during operation drops any in-flight result.
- Latency: 1 cycle.
  - When in_valid=1 at a clk edge, out_bcd, carry_out and err load the result, and out_valid=1 on the following cycle.
  - When in_valid=0, out_valid=0 on the next edge; out_bcd, carry_out and err keep their last values.
- No backpressure. A new operand may be accepted every cycle.
- Arithmetic, per digit k, with carry c0=1 into digit 0:
  - if c_k=1 and d_k>=9: r_k=0 and c_{k+1}=1
  - if c_k=1 and d_k<9: r_k=d_k+1 and c_{k+1}=0
  - if c_k=0: r_k=d_k and c_{k+1}=0
- carry_out = c_NUM_DIGITS, meaning every digit was 9 and the result is all zeros (999 -> 000 with carry_out=1).
- Digit values A-F when BCD_CHECK_EN is not defined:
  - Treated as ">=9": the digit becomes 0 and propagates the carry only if it receives one.
  - If no carry arrives, the digit passes through unchanged.
- Purely combinational next-value logic feeds the output registers. There are no internal state machines.

Optional Feature:
Macro BCD_CHECK_EN.
- Defined: any input digit greater than 9 causes the captured result to be:
  - err=1
  - out_bcd = in_bcd unchanged
  - carry_out=0
  - out_valid behaves as usual.
  - Valid inputs give err=0.
- Not defined: err is constant 0, and invalid digits follow the ">=9" rule above.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W=4
  - BCD_MAX=4'd9
  - typedef logic [3:0] bcd_digit_t
  - function is_valid_digit
- Sub-module bcd_digit_inc: combinational single-digit incrementer.
  - Inputs: digit, carry_in.
  - Outputs: digit_out, carry_out, invalid.
  - Instantiated NUM_DIGITS times in a generate ripple chain.
- The top level holds only the generate chain, the error OR-reduction and the output registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and in_bcd=12'h123 -> out_valid=0, out_bcd=12'h000, carry_out=0, err=0, asserted asynchronously without waiting for a clk edge.
- No carry: in_bcd=12'h123, in_valid=1 for one cycle -> next cycle out_bcd=12'h124, out_valid=1, carry_out=0; the following cycle out_valid=0 and out_bcd holds 12'h124.
- Carry chains: stream 12'h129, 12'h199, 12'h409 back-to-back -> 12'h130, 12'h200, 12'h410 on consecutive cycles, out_valid held at 1.
- Wrap: in_bcd=12'h999 -> out_bcd=12'h000, carry_out=1; next input 12'h000 -> 12'h001, carry_out=0.
- Reset mid-stream: pulse rst_n low between two valid inputs -> outputs clear immediately; the first post-reset valid input 12'h058 -> 12'h059.
- Invalid digit, 12'h1A9:
  - BCD_CHECK_EN defined -> err=1, out_bcd=12'h1A9, carry_out=0.
  - Not defined -> out_bcd=12'h200, err=0.
